// File: rtl/banco_arbiter_pkg.sv
// Shared encodings for the banco register-bank arbiter: FSM states,
// grant identifiers and the hard-wired zero register index.
package banco_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_RS  = 3'd1,
        ST_RD_RT  = 3'd2,
        ST_RD_CAP = 3'd3,
        ST_RD_ACK = 3'd4,
        ST_WR     = 3'd5,
        ST_WR_ACK = 3'd6
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/banco_arbiter.sv
// Serialises operand reads and write-backs onto the single-port banco bank,
// alternating between requesters on contention and forcing register 0 to zero.
module banco_arbiter
    import banco_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] bank_address,
    output logic              bank_enable_write,
    output logic              bank_enable_read,
    output logic [DATA_W-1:0] bank_in_data,
    input  logic [DATA_W-1:0] bank_out_data
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rt_q, rt_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_RD;
            rs_q         <= '0;
            rt_q         <= '0;
            wa_q         <= '0;
            wd_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        wa_d         = wa_q;
        wd_d         = wd_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        case (state_q)
            ST_IDLE: begin
                // On contention the requester that did not win last time goes first.
                if (wr_req && (!rd_req || last_grant_q == GRANT_RD)) begin
                    state_d      = ST_WR;
                    last_grant_d = GRANT_WR;
                    wa_d         = wr_addr;
                    wd_d         = wr_data;
                end else if (rd_req) begin
                    state_d      = ST_RD_RS;
                    last_grant_d = GRANT_RD;
                    rs_d         = rs_addr;
                    rt_d         = rt_addr;
                end
            end
            ST_RD_RS:  state_d = ST_RD_RT;
            ST_RD_RT: begin
                state_d   = ST_RD_CAP;
                rs_data_d = (rs_q == ZERO_IDX) ? '0 : bank_out_data;
            end
            ST_RD_CAP: begin
                state_d   = ST_RD_ACK;
                rt_data_d = (rt_q == ZERO_IDX) ? '0 : bank_out_data;
            end
            ST_RD_ACK: state_d = ST_IDLE;
            ST_WR:     state_d = ST_WR_ACK;
            ST_WR_ACK: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bank-side and handshake outputs are pure state decode so reset clears them at once.
    always_comb begin
        bank_address      = '0;
        bank_enable_read  = 1'b0;
        bank_enable_write = 1'b0;
        bank_in_data      = '0;
        rd_ack            = 1'b0;
        wr_ack            = 1'b0;
        case (state_q)
            ST_RD_RS: begin
                bank_address     = rs_q;
                bank_enable_read = 1'b1;
            end
            ST_RD_RT: begin
                bank_address     = rt_q;
                bank_enable_read = 1'b1;
            end
            ST_RD_ACK: rd_ack = 1'b1;
            ST_WR: begin
                bank_address      = wa_q;
                bank_in_data      = wd_q;
                bank_enable_write = (wa_q != ZERO_IDX);
            end
            ST_WR_ACK: wr_ack = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign rs_data = rs_data_q;
    assign rt_data = rt_data_q;

endmodule

// File: tb/tb_banco_arbiter.sv
// Scoreboard bench for banco_arbiter with a behavioural single-port bank
// (registered read, 1-cycle latency) attached to the bank_* ports.
module tb_banco_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rs_addr = '0;
    logic [AW-1:0] rt_addr = '0;
    logic          rd_ack;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          busy;
    logic [AW-1:0] bank_address;
    logic          bank_enable_write;
    logic          bank_enable_read;
    logic [DW-1:0] bank_in_data;
    logic [DW-1:0] bank_out_data = '0;

    always #5 clock = ~clock;

    banco_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .rd_req(rd_req), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_ack(rd_ack), .rs_data(rs_data), .rt_data(rt_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy),
        .bank_address(bank_address), .bank_enable_write(bank_enable_write),
        .bank_enable_read(bank_enable_read), .bank_in_data(bank_in_data),
        .bank_out_data(bank_out_data)
    );

    // Behavioural banco: contents survive the arbiter's reset.
    logic [DW-1:0] mem [32] = '{default: '0};
    always @(posedge clock) begin
        if (bank_enable_write) mem[bank_address] <= bank_in_data;
        if (bank_enable_read)  bank_out_data     <= mem[bank_address];
    end

    typedef struct {
        bit            is_rd;
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
        bit            we;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a);
        exp_t e;
        e.is_rd = 1'b0; e.rs = '0; e.rt = '0; e.we = (a != 5'd0);
        sb.push_back(e);
    endtask

    task automatic push_rd(input logic [DW-1:0] ers, input logic [DW-1:0] ert);
        exp_t e;
        e.is_rd = 1'b1; e.rs = ers; e.rt = ert; e.we = 1'b0;
        sb.push_back(e);
    endtask

    // Monitor: enable exclusivity every cycle, and scoreboard pop on each ack.
    bit   we_seen = 1'b0;
    exp_t mon_e;
    always @(negedge clock) begin
        if (reset) begin
            we_seen = 1'b0;
        end else begin
            chk("en_exclusive", 32'(bank_enable_read & bank_enable_write), 32'd0);
            if (bank_enable_write) we_seen = 1'b1;
            if (rd_ack || wr_ack) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: rd_ack=%b wr_ack=%b, none expected at %0t",
                             rd_ack, wr_ack, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_is_read", 32'(rd_ack), 32'(mon_e.is_rd));
                    chk("ack_is_write", 32'(wr_ack), 32'(!mon_e.is_rd));
                    if (mon_e.is_rd) begin
                        chk("rs_data", rs_data, mon_e.rs);
                        chk("rt_data", rt_data, mon_e.rt);
                    end else begin
                        chk("bank_write_done", 32'(we_seen), 32'(mon_e.we));
                    end
                end
                we_seen = 1'b0;
            end
        end
    end

    task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        push_wr(a);
        @(posedge clock); #1;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        n = 0;
        @(negedge clock);
        while (!wr_ack && n < 20) begin @(negedge clock); n++; end
        chk("wr_latency", 32'(n), 32'd2);
        @(posedge clock); #1;
        wr_req = 1'b0;
    endtask

    task automatic rd_txn(input logic [AW-1:0] s, input logic [AW-1:0] t,
                          input logic [DW-1:0] ers, input logic [DW-1:0] ert);
        int n;
        push_rd(ers, ert);
        @(posedge clock); #1;
        rd_req = 1'b1; rs_addr = s; rt_addr = t;
        n = 0;
        @(negedge clock);
        while (!rd_ack && n < 20) begin @(negedge clock); n++; end
        chk("rd_latency", 32'(n), 32'd4);
        @(posedge clock); #1;
        rd_req = 1'b0;
    endtask

    // Both requests raised in the same cycle; caller pushes expectations in grant order.
    task automatic pair_txn(input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic [AW-1:0] s, input logic [AW-1:0] t,
                            input int exp_wcyc, input int exp_rcyc);
        int n, wcyc, rcyc;
        bit wdone, rdone;
        @(posedge clock); #1;
        wr_req = 1'b1; wr_addr = wa; wr_data = wd;
        rd_req = 1'b1; rs_addr = s;  rt_addr = t;
        n = 0; wcyc = -1; rcyc = -1; wdone = 0; rdone = 0;
        while (!(wdone && rdone) && n < 40) begin
            @(negedge clock);
            if (wr_ack) begin wdone = 1; wcyc = n; end
            if (rd_ack) begin rdone = 1; rcyc = n; end
            @(posedge clock); #1;
            if (wdone) wr_req = 1'b0;
            if (rdone) rd_req = 1'b0;
            n++;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        chk("pair_wr_ack_cycle", 32'(wcyc), 32'(exp_wcyc));
        chk("pair_rd_ack_cycle", 32'(rcyc), 32'(exp_rcyc));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_ack"}, 32'(rd_ack), 32'd0);
        chk({tag, "_wr_ack"}, 32'(wr_ack), 32'd0);
        chk({tag, "_en_rd"}, 32'(bank_enable_read), 32'd0);
        chk({tag, "_en_wr"}, 32'(bank_enable_write), 32'd0);
        chk({tag, "_addr"}, 32'(bank_address), 32'd0);
        chk({tag, "_in_data"}, bank_in_data, 32'd0);
        chk({tag, "_rs_data"}, rs_data, 32'd0);
        chk({tag, "_rt_data"}, rt_data, 32'd0);
    endtask

    initial begin
        #3;
        chk_all_zero("reset0");
        #19 reset = 1'b0;

        // Basic write then read, rt=0 forced to zero.
        wr_txn(5'd5, 32'hDEADBEEF);
        rd_txn(5'd5, 5'd0, 32'hDEADBEEF, 32'h0);

        // Write to r0 is dropped but acknowledged.
        wr_txn(5'd0, 32'h12345678);
        rd_txn(5'd0, 5'd0, 32'h0, 32'h0);

        // First contention after reset: write wins.
        push_wr(5'd7);
        push_rd(32'hA5A5A5A5, 32'hA5A5A5A5);
        pair_txn(5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 2, 7);

        // After a write grant, contention goes to the read (sees old r9 = 0).
        wr_txn(5'd8, 32'h00000001);
        push_rd(32'hA5A5A5A5, 32'h0);
        push_wr(5'd9);
        pair_txn(5'd9, 32'h00000099, 5'd7, 5'd9, 7, 4);
        rd_txn(5'd9, 5'd8, 32'h00000099, 32'h00000001);

        // Reset while in RD_RT: outputs clear immediately, no ack follows.
        @(posedge clock); #1;
        rd_req = 1'b1; rs_addr = 5'd5; rt_addr = 5'd7;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("pre_reset_en_rd", 32'(bank_enable_read), 32'd1);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1 chk_all_zero("midreset");
        rd_req = 1'b0;
        @(posedge clock);
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (4) @(negedge clock);
        rd_txn(5'd5, 5'd7, 32'hDEADBEEF, 32'hA5A5A5A5);

        // rs == rt on the top register.
        wr_txn(5'd31, 32'h0000FFFF);
        rd_txn(5'd31, 5'd31, 32'h0000FFFF, 32'h0000FFFF);

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/banco_arbiter.md
# banco_arbiter

Sequencer and two-requester arbiter for the single-port 32x32 register bank (`banco`). It shares the bank's single address port between an operand-read requester (decode, two operands per request) and a write-back requester. It serialises their accesses into legal bank cycles and never asserts read and write enables together. It also enforces register 0 as hard-wired zero.

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `rd_req`  in  1  operand-read request, held until `rd_ack`
- `rs_addr`  in  ADDR_W  first operand index
- `rt_addr`  in  ADDR_W  second operand index
- `rd_ack`  out  1  one-cycle pulse; `rs_data`/`rt_data` valid in this cycle
- `rs_data`  out  DATA_W  first operand, held until next read completes
- `rt_data`  out  DATA_W  second operand, held until next read completes
- `wr_req`  in  1  write request, held until `wr_ack`
- `wr_addr`  in  ADDR_W  destination index
- `wr_data`  in  DATA_W  write value
- `wr_ack`  out  1  one-cycle pulse; write has been committed
- `busy`  out  1  state != IDLE
- `bank_address`  out  ADDR_W  to bank `address`
- `bank_enable_write`  out  1  to bank `enable_write`
- `bank_enable_read`  out  1  to bank `enable_read`
- `bank_in_data`  out  DATA_W  to bank `in_data`
- `bank_out_data`  in  DATA_W  from bank `out_data`; registered, 1-cycle read latency

## Operation
- FSM states: IDLE, RD_RS, RD_RT, RD_CAP, RD_ACK, WR, WR_ACK.
- IDLE: if exactly one request is present, grant it. If both are present, grant per `last_grant`: grant write if the last grant was read, else read. After reset, `last_grant` is "read", so write wins first. On grant, latch all addresses and data and update `last_grant`.
- Read sequence: RD_RS → RD_RT → RD_CAP → RD_ACK → IDLE.
  - RD_RS: `bank_address`=rs, `bank_enable_read`=1.
  - RD_RT: `bank_address`=rt, `bank_enable_read`=1. At the edge, `rs_data` <= `bank_out_data`, or 0 if rs==0.
  - RD_CAP: enables low. At the edge, `rt_data` <= `bank_out_data`, or 0 if rt==0.
  - RD_ACK: `rd_ack`=1.
- Write sequence: WR → WR_ACK → IDLE.
  - WR: `bank_address`=wr_addr, `bank_in_data`=wr_data, `bank_enable_write`=1 unless wr_addr==0. A write to 0 is dropped silently but still acknowledged.
  - WR_ACK: `wr_ack`=1.
- Bank-side outputs and `rd_ack`/`wr_ack`/`busy` are decoded from state and latched registers. In IDLE, all bank outputs are 0.
- `bank_enable_write` and `bank_enable_read` are never both 1.
- Requests are not re-sampled until the FSM returns to IDLE. A requester deasserts `*_req` in the cycle after its ack.
- No forwarding is needed: accesses are serialised, so a read granted after a write always sees the new value.

## Timing
- Reset values: state IDLE, `last_grant`=read, `rs_data`=`rt_data`=0, all ack/enable/`busy`/`bank_*` outputs 0. The reset is asynchronous, so outputs clear in the same cycle `reset` rises.
- Read: granted in IDLE cycle 0, `rd_ack` in cycle 4, next grant possible in cycle 5.
- Write: granted in cycle 0, bank write at the end of cycle 1, `wr_ack` in cycle 2, IDLE in cycle 3.
- Simultaneous requests alternate strictly, so no starvation. Worst-case wait is one opposite transaction (5 cycles).
- Reset mid-operation: return to IDLE and suppress any pending ack. A write whose edge has not occurred is not performed. The requester reissues its request.
- rs==rt is legal; both reads are issued and both operands return the same value.

## Structure
- Shared header/package: state encodings (localparams), `REG_ZERO`=5'd0, `GRANT_RD`/`GRANT_WR` encodings.
- No sub-module is needed. Arbitration is a single `last_grant` flop inside the FSM. `banco` is instantiated only in the testbench, wired to the `bank_*` ports.

## Test plan
- Reset asserted mid-simulation → all outputs 0 that cycle; `busy`=0; IDLE after release.
- Write r5=32'hDEADBEEF, then read rs=5, rt=0 → `wr_ack` at cycle 2; `rd_ack` 4 cycles after grant with `rs_data`=DEADBEEF and `rt_data`=0.
- Write r0=32'h12345678 → `bank_enable_write` never high, `wr_ack` pulses. A subsequent read of rs=0, rt=0 returns 0, 0.
- `rd_req` and `wr_req` raised together after reset, then again → write (r7=32'hA5A5A5A5) granted first and the read of r7 returns A5A5A5A5. On the next simultaneous pair, read is granted first.
- Reset pulsed while in RD_RT → `bank_enable_read` drops immediately, no `rd_ack`. The reissued read returns correct values.
- Read rs=rt=31 after writing 32'h0000_FFFF → both operands equal 0000FFFF. Checker confirms the enables are never both high throughout.
